mux_arbiter: RTL and testbench
==============================

// Module: mux_arbiter
// PURPOSE
//  Shares the 32-bit operand register path between two requesters.
//  - Port A supplies a full 32-bit word; port B supplies a 16-bit value that is widened to 32 bits.
//  - Burst-limited round-robin arbitration; one transfer accepted per cycle.
//  - Result lands in a registered output slot with valid/ready handshake, plus the mux select it used.
// PARAMETERS
//  MAX_BURST  4  max consecutive accepts by one source while the other is also valid (>=1)
//  CNT_W      3  width of burst counter; must hold MAX_BURST
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  a_valid    in   1   port A word available
//  a_data     in   32  port A word
//  a_ready    out  1   port A accepted this cycle (combinational)
//  b_valid    in   1   port B value available
//  b_data     in   16  port B value
//  b_ready    out  1   port B accepted this cycle (combinational)
//  out_valid  out  1   output slot holds a word
//  out_data   out  32  registered output word
//  out_src    out  1   source of out_data: 0=A, 1=B
//  out_ready  in   1   consumer takes out_data when out_valid&&out_ready
//  sel        out  1   mux select for downstream; equals out_src
// BEHAVIOUR
//  Reset:
//   - out_valid=0, out_data=0, out_src=0, sel=0, last_src=0, burst_cnt=0.
//   - a_ready=b_ready=0 while rst=1.
//  FSM (out_valid is the state bit):
//   - EMPTY: slot free.
//   - FULL: slot holds a word.
//   - slot_free = EMPTY || (FULL && out_ready).
//  Grant (combinational, evaluated only when slot_free):
//   - only A valid -> A; only B valid -> B; neither -> none.
//   - both valid: burst_cnt<MAX_BURST -> last_src; else -> ~last_src.
//   - a_ready = slot_free && grant==A; b_ready = slot_free && grant==B. Never both high.
//  Accept (posedge with X_valid&&X_ready):
//   - out_data <= A: a_data; B: widened b_data.
//   - out_src <= grant; out_valid <= 1; state=FULL.
//   - grant==last_src: burst_cnt <= min(burst_cnt+1, MAX_BURST).
//   - else: last_src <= grant, burst_cnt <= 1.
//  Drain: FULL && out_ready && no accept -> out_valid <= 0 (EMPTY). out_data and out_src hold.
//  Latency:
//   - 1 cycle accept -> out_valid.
//   - Simultaneous drain+accept in FULL keeps out_valid=1 and loads the new word: full throughput, 1 word/cycle.
//  Backpressure: FULL && !out_ready -> out_* stable, no accept, burst_cnt/last_src hold.
//  Single requester: never starved; burst_cnt saturates at MAX_BURST. The first contested cycle afterwards grants the other source.
//  Idle cycles (no accept): burst_cnt holds; it is not cleared.
//  Reset mid-operation: the in-flight word is dropped; no accept is reported that cycle.
//  sel is out_src; it changes only on accept.
// CONFIGURATION
//  SIGN_EXT_EN defined:     B widened as {{16{b_data[15]}}, b_data}.
//  SIGN_EXT_EN not defined: B widened as {16'h0000, b_data}.
//  No other logic differs.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0; a_ready=b_ready=0 even with a_valid=b_valid=1.
//  2. a_valid=1, a_data=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=DEADBEEF, out_src=0, sel=0.
//  3. b_data=16'h8001 alone -> out_data=32'h00008001 (no macro) / 32'hFFFF8001 (SIGN_EXT_EN).
//  4. Both valid continuously, out_ready=1, MAX_BURST=4 -> accept order A,A,A,A,B,B,B,B,A...; a_ready&b_ready never both 1.
//  5. FULL with out_ready=0 for 5 cycles -> out_data stable, a_ready=b_ready=0; out_ready=1 -> drain plus new accept same cycle.
//  6. rst asserted while out_valid=1 -> next cycle out_valid=0; the next contested grant goes to A.

Source files
------------

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - burst-limited round-robin arbiter sharing one registered 32-bit output slot between A and B
// Optional macro SIGN_EXT_EN: sign-extends port B when widening (zero-extends otherwise).
module mux_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_src,
    input  logic        out_ready,
    output logic        sel
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_out_data;
    logic             r_out_src;
    logic             r_last_src;
    logic [CNT_W-1:0] r_burst_cnt;

    logic             w_slot_free;
    logic             w_grant_any;
    logic             w_grant_b;
    logic             w_accept;
    logic [31:0]      w_b_wide;

`ifdef SIGN_EXT_EN
    assign w_b_wide = {{16{b_data[15]}}, b_data};
`else
    assign w_b_wide = {16'h0000, b_data};
`endif

    // Grant is suppressed during reset so no accept is reported in that cycle.
    always_comb begin
        w_slot_free  = (r_state == S_EMPTY) || out_ready;
        w_grant_any  = 1'b0;
        w_grant_b    = 1'b0;
        if (!rst && w_slot_free) begin
            if (a_valid && b_valid) begin
                w_grant_any = 1'b1;
                w_grant_b   = (r_burst_cnt < MAX_CNT) ? r_last_src : ~r_last_src;
            end else if (a_valid) begin
                w_grant_any = 1'b1;
                w_grant_b   = 1'b0;
            end else if (b_valid) begin
                w_grant_any = 1'b1;
                w_grant_b   = 1'b1;
            end
        end
        w_accept = w_grant_any;
        a_ready  = w_grant_any && !w_grant_b;
        b_ready  = w_grant_any && w_grant_b;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = S_FULL;
        end else if (r_state == S_FULL && out_ready) begin
            w_next_state = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= 32'h0;
            r_out_src   <= 1'b0;
            r_last_src  <= 1'b0;
            r_burst_cnt <= '0;
        end else if (w_accept) begin
            r_out_data <= w_grant_b ? w_b_wide : a_data;
            r_out_src  <= w_grant_b;
            if (w_grant_b == r_last_src) begin
                if (r_burst_cnt != MAX_CNT) begin
                    r_burst_cnt <= r_burst_cnt + ONE_CNT;
                end
            end else begin
                r_last_src  <= w_grant_b;
                r_burst_cnt <= ONE_CNT;
            end
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign sel       = r_out_src;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - randomized and directed bench for mux_arbiter against a behavioural model
module tb_mux_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [31:0] a_data = 32'h0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [15:0] b_data = 16'h0;
    logic        b_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_ready = 1'b0;
    logic        sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: slot contents plus burst bookkeeping.
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    int          m_src   = 0;
    int          m_last  = 0;
    int          m_cnt   = 0;
    int          acc_src = -1;

    always #5 clk = ~clk;

    mux_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .sel(sel)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] widen(input logic [15:0] v);
`ifdef SIGN_EXT_EN
        return 32'($signed(v));
`else
        return 32'(v);
`endif
    endfunction

    // -1 = no grant, 0 = A, 1 = B
    function automatic int model_grant();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        if (a_valid && b_valid) return (m_cnt < MAX_BURST) ? m_last : 1 - m_last;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    task automatic cycle(input logic r, input logic av, input logic [31:0] ad,
                         input logic bv, input logic [15:0] bd, input logic orr);
        int g;
        @(negedge clk);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = orr;
        #1;
        g = model_grant();
        chk("a_ready", a_ready, g == 0);
        chk("b_ready", b_ready, g == 1);
        @(posedge clk);
        acc_src = g;
        if (r) begin
            m_valid = 1'b0; m_data = 32'h0; m_src = 0; m_last = 0; m_cnt = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = (g == 0) ? ad : widen(bd);
            m_src   = g;
            if (g == m_last) m_cnt = (m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1;
            else begin m_last = g; m_cnt = 1; end
        end else if (m_valid && orr) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src[0]);
        chk("sel", sel, m_src[0]);
    endtask

    initial begin
        logic [31:0] held;
        // Reset with both requesters active: nothing granted, outputs cleared.
        cycle(1, 1, 32'h1111_1111, 1, 16'h2222, 1);
        cycle(1, 1, 32'h1111_1111, 1, 16'h2222, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);

        // Single A word.
        cycle(0, 1, 32'hDEAD_BEEF, 0, 16'h0, 1);
        chk("a_word", out_data, 32'hDEAD_BEEF);
        chk("a_src", out_src, 0);

        // Single B word exercises the widening.
        cycle(0, 0, 32'h0, 1, 16'h8001, 1);
`ifdef SIGN_EXT_EN
        chk("b_widen", out_data, 32'hFFFF_8001);
`else
        chk("b_widen", out_data, 32'h0000_8001);
`endif
        chk("b_src", out_src, 1);

        // Contested stream from fresh reset: A x4, B x4, A x4.
        cycle(1, 0, 32'h0, 0, 16'h0, 1);
        for (int k = 0; k < 12; k++) begin
            cycle(0, 1, 32'hA000_0000 + k, 1, 16'(16'hB000 + k), 1);
            chk("burst_order", acc_src, (k / 4) % 2);
        end

        // Backpressure for 5 cycles, then drain and accept in the same cycle.
        cycle(0, 1, 32'h1234_5678, 0, 16'h0, 0);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 32'hCAFE_0000 + k, 1, 16'h5555, 0);
            chk("bp_hold", out_data, held);
        end
        cycle(0, 1, 32'h0BAD_F00D, 0, 16'h0, 1);
        chk("drain_accept_valid", out_valid, 1);
        chk("drain_accept_data", out_data, 32'h0BAD_F00D);

        // Saturate B alone, then reset mid-flight: first contested grant is A.
        for (int k = 0; k < 6; k++) cycle(0, 0, 32'h0, 1, 16'(k), 0 + 1);
        cycle(1, 1, 32'h0, 1, 16'h0, 0);
        chk("rst_drop", out_valid, 0);
        cycle(0, 1, 32'h7777_7777, 1, 16'h9999, 1);
        chk("post_rst_grant", acc_src, 0);

        // Saturated single requester hands over on first contest.
        for (int k = 0; k < 6; k++) cycle(0, 1, 32'h100 + k, 0, 16'h0, 1);
        cycle(0, 1, 32'h200, 1, 16'h0300, 1);
        chk("sat_handover", acc_src, 1);

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0), $urandom(),
                  ($urandom_range(0, 3) != 0), 16'($urandom()),
                  ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
